accum_seq: RTL and testbench

- Sequential accumulator sitting directly downstream of the 4-bit add_sub unit.
- Holds a registered 4-bit accumulator and feeds it back as opA to the add_sub datapath.
- Applies a stream of (opB, opSel) operations via a valid/ready handshake, keeps a sticky signed-overflow flag, and presents the final result after NUM_OPS operations.

---
 rtl/accum_seq_pkg.sv | 13 +
 rtl/accum_seq_if.sv | 28 ++
 rtl/accum_seq_add_sub.sv | 24 ++
 rtl/accum_seq.sv | 87 ++++++++
 tb/tb_accum_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accum_seq accumulator and its add_sub datapath.
package accum_seq_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/accum_seq_if.sv
// Bundles the run control, operation stream and result signals of accum_seq.
interface accum_seq_if;
  import accum_seq_pkg::*;

  logic             Start;
  logic [WIDTH-1:0] InitVal;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] opB;
  logic             opSel;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] Result;
  logic             Overflow;
  logic [CNT_W-1:0] OpCount;
  logic             Busy;

  modport master (
    output Start, InitVal, inValid, opB, opSel, outReady,
    input  inReady, outValid, Result, Overflow, OpCount, Busy
  );

  modport slave (
    input  Start, InitVal, inValid, opB, opSel, outReady,
    output inReady, outValid, Result, Overflow, OpCount, Busy
  );

endinterface

// File: rtl/accum_seq_add_sub.sv
// Combinational 4-bit add/subtract unit with two's complement overflow detection.
module add_sub
  import accum_seq_pkg::*;
(
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             opSel
);

  always_comb begin
    Sum      = '0;
    Overflow = 1'b0;
    if (opSel) begin
      Sum      = opA - opB;
      Overflow = (opA[WIDTH-1] != opB[WIDTH-1]) && (Sum[WIDTH-1] != opA[WIDTH-1]);
    end else begin
      Sum      = opA + opB;
      Overflow = (opA[WIDTH-1] == opB[WIDTH-1]) && (Sum[WIDTH-1] != opA[WIDTH-1]);
    end
  end

endmodule

// File: rtl/accum_seq.sv
// Sequential accumulator: seeds on Start, folds NUM_OPS add/sub operations into a
// registered accumulator with a sticky overflow flag, then presents the result.
module accum_seq
  import accum_seq_pkg::*;
#(
  parameter int NUM_OPS = 4
)
(
  input logic         Clk,
  input logic         Rst_n,
  accum_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;

  add_sub u_add_sub (
    .Sum      (sum),
    .Overflow (sum_ovf),
    .opA      (acc_q),
    .opB      (bus.opB),
    .opSel    (bus.opSel)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // In ACCUM the handshake is just inValid, since inReady is the ACCUM decode itself.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          acc_d   = bus.InitVal;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.inValid) begin
          acc_d = sum;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_OP) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inReady  = (state_q == ACCUM);
  assign bus.outValid = (state_q == DONE);
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Result   = acc_q;
  assign bus.Overflow = ovf_q;
  assign bus.OpCount  = cnt_q;

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq: directed scenarios plus randomized traffic,
// all compared against a signed-arithmetic reference model.
module tb_accum_seq;

  localparam int NUM_OPS = 4;

  logic Clk;
  logic Rst_n;
  accum_seq_if bus();

  accum_seq #(.NUM_OPS(NUM_OPS)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = waiting for Start, 1 = taking ops, 2 = holding result.
  int mPhase, mAcc, mOvf, mCnt;
  int nPhase, nAcc, nOvf, nCnt;

  function automatic int toSigned(input logic [3:0] v);
    int u;
    u = int'(v);
    return (u > 7) ? u - 16 : u;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mAcc = 0; mOvf = 0; mCnt = 0;
  endtask

  task automatic modelNext();
    int trueVal;
    nPhase = mPhase; nAcc = mAcc; nOvf = mOvf; nCnt = mCnt;
    if (mPhase == 0) begin
      if (bus.Start) begin
        nAcc = int'(bus.InitVal); nOvf = 0; nCnt = 0; nPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (bus.inValid) begin
        if (bus.opSel)
          trueVal = toSigned(4'(mAcc)) - toSigned(bus.opB);
        else
          trueVal = toSigned(4'(mAcc)) + toSigned(bus.opB);
        nAcc = (trueVal + 16) % 16;
        nOvf = mOvf | ((trueVal > 7 || trueVal < -8) ? 1 : 0);
        nCnt = mCnt + 1;
        if (nCnt == NUM_OPS) nPhase = 2;
      end
    end else begin
      if (bus.outReady) nPhase = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " Result"},   bus.Result,   mAcc);
    checkOutput({tag, " Overflow"}, bus.Overflow, mOvf);
    checkOutput({tag, " OpCount"},  bus.OpCount,  mCnt);
    checkOutput({tag, " outValid"}, bus.outValid, (mPhase == 2) ? 1 : 0);
    checkOutput({tag, " inReady"},  bus.inReady,  (mPhase == 1) ? 1 : 0);
    checkOutput({tag, " Busy"},     bus.Busy,     (mPhase != 0) ? 1 : 0);
  endtask

  // Drives one cycle of inputs, clocks it, and compares outputs against the model.
  task automatic applyStimulus(input logic start, input logic [3:0] initVal, input logic valid,
                               input logic [3:0] b, input logic sel, input logic oReady,
                               input string tag);
    bus.Start = start; bus.InitVal = initVal; bus.inValid = valid;
    bus.opB = b; bus.opSel = sel; bus.outReady = oReady;
    modelNext();
    @(posedge Clk);
    #1;
    mPhase = nPhase; mAcc = nAcc; mOvf = nOvf; mCnt = nCnt;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    Rst_n = 1'b0;
    #2;
    modelReset();
    checkAll(tag);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    checkAll({tag, " release"});
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic startRun(input logic [3:0] initVal, input string tag);
    applyStimulus(1'b1, initVal, 1'b0, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic doOp(input logic [3:0] b, input logic sel, input string tag);
    applyStimulus(1'b0, 4'h0, 1'b1, b, sel, 1'b0, tag);
  endtask

  task automatic drainDone(input string tag);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    logic [3:0] seq2B [4];
    logic       seq2S [4];
    int         seq2R [4];
    logic [3:0] holdRes;
    logic       vPat [6];

    seq2B = '{4'd2, 4'd1, 4'd4, 4'd5};
    seq2S = '{1'b0, 1'b0, 1'b1, 1'b0};
    seq2R = '{5, 6, 2, 7};
    vPat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    bus.Start = 0; bus.InitVal = 0; bus.inValid = 0; bus.opB = 0;
    bus.opSel = 0; bus.outReady = 0;
    Rst_n = 1'b0;
    modelReset();
    #12;
    checkAll("por");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    idleCycle("idle");

    // Reset in the middle of ACCUM
    startRun(4'd5, "s1 start");
    doOp(4'd1, 1'b0, "s1 op");
    doReset("s1 reset");
    checkOutput("s1 Result zero", bus.Result, 0);
    checkOutput("s1 Busy zero", bus.Busy, 0);

    // Basic run: 3 +2 +1 -4 +5
    startRun(4'd3, "s2 start");
    for (int i = 0; i < 4; i++) begin
      doOp(seq2B[i], seq2S[i], "s2 op");
      checkOutput("s2 seq", bus.Result, seq2R[i]);
    end
    checkOutput("s2 outValid", bus.outValid, 1);
    checkOutput("s2 OpCount", bus.OpCount, 4);
    checkOutput("s2 Overflow", bus.Overflow, 0);
    drainDone("s2 drain");

    // Sticky overflow
    startRun(4'd6, "s3 start");
    doOp(4'd3, 1'b0, "s3 op");
    checkOutput("s3 ovf first", bus.Overflow, 1);
    for (int i = 0; i < 3; i++) doOp(4'd0, 1'b0, "s3 op0");
    checkOutput("s3 Result", bus.Result, 9);
    checkOutput("s3 ovf held", bus.Overflow, 1);
    drainDone("s3 drain");
    startRun(4'd0, "s3 restart");
    checkOutput("s3 ovf cleared", bus.Overflow, 0);

    // Subtract wrap (continues from the run started above)
    doOp(4'd1, 1'b1, "s4a op");
    for (int i = 0; i < 3; i++) doOp(4'd0, 1'b0, "s4a op0");
    checkOutput("s4a Result", bus.Result, 15);
    checkOutput("s4a Overflow", bus.Overflow, 0);
    drainDone("s4a drain");
    startRun(4'd8, "s4b start");
    doOp(4'd1, 1'b1, "s4b op");
    for (int i = 0; i < 3; i++) doOp(4'd0, 1'b0, "s4b op0");
    checkOutput("s4b Result", bus.Result, 7);
    checkOutput("s4b Overflow", bus.Overflow, 1);
    drainDone("s4b drain");

    // Backpressure and DONE holding
    startRun(4'd1, "s5 start");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 4'h0, vPat[i], 4'd1, 1'b0, 1'b0, "s5 bp");
    checkOutput("s5 count", bus.OpCount, 4);
    checkOutput("s5 Result", bus.Result, 5);
    holdRes = bus.Result;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'hA, 1'b1, 4'd3, 1'b0, 1'b0, "s5 hold");
      checkOutput("s5 hold Result", bus.Result, 5);
      checkOutput("s5 hold outValid", bus.outValid, 1);
    end
    applyStimulus(1'b1, 4'hA, 1'b1, 4'd3, 1'b0, 1'b1, "s5 exit");
    checkOutput("s5 exit Busy", bus.Busy, 0);
    checkOutput("s5 kept Result", bus.Result, holdRes);
    idleCycle("s5 idle");

    // Reset after 2 of 4 ops, then a clean rerun
    startRun(4'd3, "s6 start");
    doOp(4'd2, 1'b0, "s6 op");
    doOp(4'd1, 1'b0, "s6 op");
    doReset("s6 reset");
    startRun(4'd3, "s6 rerun");
    for (int i = 0; i < 4; i++) doOp(seq2B[i], seq2S[i], "s6 op2");
    checkOutput("s6 final", bus.Result, 7);
    drainDone("s6 drain");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset("rnd reset");
      end else begin
        applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
